// File: rtl/interrupt_controller_if.sv
// Bus and interrupt-handshake bundle between the CPU core and the
// interrupt controller: core side is master, controller side is slave.
interface interrupt_controller_if;
    logic        select;
    logic        read;
    logic        write;
    logic [3:0]  bwe;
    logic [3:0]  address;
    logic [31:0] dataOut;
    logic [31:0] dataIn;
    logic        readValid;
    logic        waitRequest;
    logic        interruptRequest;
    logic [3:0]  interruptIn;
    logic        interruptAcknowledge;
    logic [3:0]  interruptOut;

    modport master (
        output select, read, write, bwe, address, dataOut,
        output interruptAcknowledge, interruptOut,
        input  dataIn, readValid, waitRequest,
        input  interruptRequest, interruptIn
    );

    modport slave (
        input  select, read, write, bwe, address, dataOut,
        input  interruptAcknowledge, interruptOut,
        output dataIn, readValid, waitRequest,
        output interruptRequest, interruptIn
    );
endinterface

// File: rtl/interrupt_controller.sv
// 16-source interrupt controller: edge/level latching, mask, fixed
// priority with nesting, one vector at a time toward the core.
// Ports: clk, reset (sync, active-low), irq[15:0], bus (slave modport:
// register bus PENDING/MASK/MODE/INSERVICE plus interrupt handshake).
module interrupt_controller (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [15:0]                  irq,
    interrupt_controller_if.slave        bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [15:0] r_irq;
    logic [15:0] r_pend;
    logic [15:0] r_mask;
    logic [15:0] r_mode;
    logic [15:0] r_insvc;
    logic [1:0]  r_state;
    logic [3:0]  r_vec;
    logic        r_rv;
    logic [31:0] r_rdata;

    logic        w_wr;
    logic        w_rd;
    logic [1:0]  w_sel;
    logic [15:0] w_lanes;
    logic [15:0] w_wbits;
    logic [15:0] w_w1c;
    logic [15:0] w_eoi;
    logic        w_ack;
    logic [15:0] w_ack_bit;
    logic [15:0] w_rise;
    logic [15:0] w_pend_nxt;
    logic [15:0] w_insvc_nxt;
    logic [15:0] w_limit;
    logic [15:0] w_cand;
    logic        w_found;
    logic [3:0]  w_idx;
    logic [15:0] w_rsel;

    assign w_wr    = bus.select & bus.write;
    assign w_rd    = bus.select & bus.read;
    assign w_sel   = bus.address[3:2];
    assign w_lanes = {{8{bus.bwe[1]}}, {8{bus.bwe[0]}}};
    assign w_wbits = bus.dataOut[15:0] & w_lanes;

    // W1C on PENDING only touches edge-mode bits
    assign w_w1c = (w_wr && w_sel == 2'd0) ? (w_wbits & r_mode) : 16'd0;
    assign w_eoi = (w_wr && w_sel == 2'd3) ? w_wbits : 16'd0;

    assign w_ack = (r_state == REQ) & bus.interruptAcknowledge
                 & (bus.interruptOut == r_vec);
    assign w_ack_bit = w_ack ? (16'd1 << r_vec) : 16'd0;

    assign w_rise = irq & ~r_irq;

    // Edge: a new rising edge beats any clear in the same cycle.
    // Level: pending simply follows the registered line.
    assign w_pend_nxt = (r_mode & ((r_pend & ~w_w1c & ~w_ack_bit) | w_rise))
                      | (~r_mode & irq);

    // Ack is OR'd last so it wins over an EOI to the same bit
    assign w_insvc_nxt = (r_insvc & ~w_eoi) | w_ack_bit;

    // Isolate lowest in-service bit, minus one gives the mask of strictly
    // higher-priority sources; wraps to all ones when nothing is in service.
    assign w_limit = (r_insvc & (~r_insvc + 16'd1)) - 16'd1;
    assign w_cand  = r_pend & r_mask & ~r_insvc & w_limit;

    always_comb begin
        w_found = 1'b0;
        w_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found = 1'b1;
                w_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        w_rsel = 16'd0;
        case (w_sel)
            2'd0:    w_rsel = r_pend;
            2'd1:    w_rsel = r_mask;
            2'd2:    w_rsel = r_mode;
            default: w_rsel = r_insvc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_irq   <= 16'd0;
            r_pend  <= 16'd0;
            r_mask  <= 16'd0;
            r_mode  <= 16'd0;
            r_insvc <= 16'd0;
            r_rv    <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_irq   <= irq;
            r_pend  <= w_pend_nxt;
            r_insvc <= w_insvc_nxt;
            if (w_wr && w_sel == 2'd1)
                r_mask <= (r_mask & ~w_lanes) | w_wbits;
            if (w_wr && w_sel == 2'd2)
                r_mode <= (r_mode & ~w_lanes) | w_wbits;
            r_rv    <= w_rd;
            r_rdata <= w_rd ? {16'd0, w_rsel} : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_vec   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_vec   <= w_idx;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (w_ack)
                        r_state <= GAP;
                end
                GAP:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.interruptRequest = (r_state == REQ);
    assign bus.interruptIn      = r_vec;
    assign bus.readValid        = r_rv;
    assign bus.dataIn           = r_rdata;
    assign bus.waitRequest      = 1'b0;
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Memory-mapped 16-source interrupt controller on the far end of the CPU core's interrupt handshake. It drives `interruptRequest`/`interruptIn` and consumes `interruptAcknowledge`/`interruptOut`. It latches edge or level requests from peripherals, applies a mask and fixed priority with nesting, and presents one vector at a time to the core. It is also a zero-wait-state slave on the core's read/write bus, used for mask, mode, pending and in-service access.

## Interface
Parameters:
- none (16 sources, 4-bit vectors are fixed by the core's interrupt port widths)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-low reset (`reset == 0` resets on the rising edge of `clk`)
- `irq`  in  16  peripheral interrupt lines, synchronous to `clk`; bit n is source n
- `select`  in  1  chip select from external address decode
- `read`  in  1  bus read strobe, qualified by `select`
- `write`  in  1  bus write strobe, qualified by `select`
- `bwe`  in  4  byte write enables; only bytes 0 and 1 are stored
- `address`  in  4  byte address; bits [3:2] select the register
- `dataOut`  in  32  write data from the core
- `dataIn`  out  32  read data to the core
- `readValid`  out  1  read data valid
- `waitRequest`  out  1  always 0 (zero wait states)
- `interruptRequest`  out  1  vector pending toward the core
- `interruptIn`  out  4  presented vector number
- `interruptAcknowledge`  in  1  one-cycle acknowledge pulse from the core
- `interruptOut`  in  4  vector number being acknowledged

## Operation
Register map (bits [31:16] read 0, writes ignored):
- 0x0 PENDING: reads return the pending bits. W1C applies to edge-mode bits only.
- 0x4 MASK: R/W, 1 = enabled. Reset value 0x0000.
- 0x8 MODE: R/W, 1 = edge, 0 = level. Reset value 0x0000.
- 0xC INSERVICE: reads return the in-service bits. W1C; writing a 1 is the end-of-interrupt (EOI) for that source.

Pending:
- Edge source: the bit sets on `irq[n]` 0→1 (compared against a registered copy of `irq`). It clears on W1C or on an accepted ack for n.
- Level source: `pending[n] = irq[n]` registered. W1C and ack have no effect.
- An edge arriving in the same cycle as a W1C of the same bit: the edge wins and the bit stays 1.

Priority:
- Source 0 is highest.
- Candidate set = `pending & mask & ~inService`, restricted to sources numerically below the lowest-numbered in-service bit (all sources qualify if nothing is in service).

Request FSM (states IDLE, REQ, GAP):
- IDLE: if the candidate set is non-empty, latch the lowest-numbered candidate into `interruptIn` and go to REQ.
- REQ:
  - `interruptRequest = 1` and `interruptIn` is frozen.
  - The request is never withdrawn, even if the source is later masked or cleared, or a higher-priority source arrives.
  - On `interruptAcknowledge == 1` with `interruptOut == interruptIn`: set `inService[interruptIn]`, clear pending if the source is edge-mode, go to GAP.
  - Ack with a mismatched vector: ignored; stay in REQ.
- GAP: one cycle with `interruptRequest = 0`, then IDLE.

Simultaneous events:
- Ack and EOI to the same bit in one cycle: the ack wins and the in-service bit ends at 1.
- EOI to other bits applies normally.

Bus:
- The write is applied at the end of the cycle where `select & write`.
- Each byte lane updates only when its `bwe` bit is set.

Reset:
- MASK, MODE, PENDING, INSERVICE and the registered `irq` copy all reset to 0.
- FSM resets to IDLE.
- `interruptRequest`, `interruptIn`, `readValid` and `dataIn` reset to 0.
- `waitRequest` is 0.
- Reset mid-request drops `interruptRequest` on the next edge with no ack required.

## Timing
- `irq` edge first high in cycle t:
  - pending is set at the end of t;
  - the FSM latches in t+1;
  - `interruptRequest` is high from t+2.
- Accepted ack in cycle a:
  - `interruptRequest` is low at a+1 (GAP);
  - IDLE at a+2;
  - the earliest next request is a+3.
- Read with `select & read` in cycle t: `readValid = 1` and `dataIn` valid in t+1 only. `dataIn` returns to 0 when `readValid = 0`.
- Read-after-write to the same register in back-to-back cycles returns the new value.
- An EOI written in cycle e makes a lower-priority source a candidate in e+1, so its request is visible at e+2.

## Test plan
- Reset with `reset = 0` for 2 cycles → all outputs 0; reads of MASK/MODE/PENDING/INSERVICE return 0.
- MODE = 0x0010, MASK = 0x0010, pulse `irq[4]` → `interruptRequest = 1`, `interruptIn = 4` two cycles later. Then ack with `interruptOut = 4` → request low next cycle, INSERVICE = 0x0010, PENDING = 0.
- Edge sources 3 and 7 pending and enabled simultaneously → vector 3 first.
  - While 3 is in service, raise source 1 → vector 1 nests.
  - Source 7 is held off until EOI writes of 0x2 and then 0x8; after them, vector 7 is presented.
- REQ with `interruptIn = 5`, ack with `interruptOut = 6` → ignored, request stays high; a matching ack is then accepted.
- Level source 2 (MODE bit 0) held high → vector 2 is acked, then not re-requested until an EOI of 0x0004; after the EOI it is re-requested at e+2.
  - A W1C of PENDING bit 2 has no effect.
- Byte lanes: write 0xFFFF to MASK with `bwe = 0001` → MASK = 0x00FF. Edge on bit 9 in the same cycle as a W1C of 0x0200 → PENDING bit 9 stays 1.
